updi_output_handler: RTL and testbench

Transmit-side counterpart of the UPDI receive path. It moves a requested number of bytes from a source FIFO into the UART TX FIFO, optionally preceded by a SYNCH byte. UPDI is a single-wire half-duplex link, so every transmitted byte echoes on RX. The block consumes each echo from the RX FIFO, checks it against the sent byte, and applies a per-byte timeout. It sits between the instruction/data sequencer and the UART TX/RX FIFOs, ahead of the receive handler in each transaction.

---
 rtl/updi_output_handler.sv | 150 +++++++++++++++
 tb/tb_updi_output_handler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_output_handler.sv
// UPDI transmit handler: moves n_bytes from a source FIFO into the UART TX FIFO
// (optionally SYNCH-prefixed), consuming and verifying each echoed byte with a per-byte timeout.
module updi_output_handler #(
  parameter int         BITS_N       = 6,
  parameter int         TIMEOUT_CLKS = 1000,
  parameter logic [7:0] SYNCH_BYTE   = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              send_synch,
  input  logic [BITS_N-1:0] n_bytes,
  output logic              ready,
  output logic              done,
  output logic              timeout,
  output logic              echo_error,
  input  logic [7:0]        src_fifo_data,
  input  logic              src_fifo_empty,
  output logic              src_fifo_rd_en,
  output logic [7:0]        tx_fifo_data,
  input  logic              tx_fifo_full,
  output logic              tx_fifo_wr_en,
  input  logic [7:0]        rx_fifo_data,
  input  logic              rx_fifo_empty,
  output logic              rx_fifo_rd_en
);

  localparam int              TO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC_READ,
    S_TX_WRITE,
    S_ECHO_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        byte_reg, byte_nxt;
  logic [BITS_N-1:0] count, count_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  // Marks that byte_reg holds the SYNCH prefix, which is not part of the payload count.
  logic              synch, synch_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_reg <= '0;
      count    <= '0;
      to_cnt   <= '0;
      synch    <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_reg <= byte_nxt;
      count    <= count_nxt;
      to_cnt   <= to_nxt;
      synch    <= synch_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    byte_nxt       = byte_reg;
    count_nxt      = count;
    to_nxt         = to_cnt;
    synch_nxt      = synch;
    ready          = 1'b0;
    done           = 1'b0;
    timeout        = 1'b0;
    echo_error     = 1'b0;
    src_fifo_rd_en = 1'b0;
    tx_fifo_data   = 8'h00;
    tx_fifo_wr_en  = 1'b0;
    rx_fifo_rd_en  = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (send_synch) begin
            byte_nxt  = SYNCH_BYTE;
            count_nxt = n_bytes;
            synch_nxt = 1'b1;
            state_nxt = S_TX_WRITE;
          end else if (n_bytes != '0) begin
            count_nxt = n_bytes;
            synch_nxt = 1'b0;
            state_nxt = S_SRC_READ;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end

      S_SRC_READ: begin
        if (!src_fifo_empty) begin
          src_fifo_rd_en = 1'b1;
          byte_nxt       = src_fifo_data;
          synch_nxt      = 1'b0;
          state_nxt      = S_TX_WRITE;
        end
      end

      S_TX_WRITE: begin
        tx_fifo_data = byte_reg;
        if (!tx_fifo_full) begin
          tx_fifo_wr_en = 1'b1;
          to_nxt        = '0;
          state_nxt     = S_ECHO_WAIT;
        end
      end

      S_ECHO_WAIT: begin
        // An echo present in the last timeout cycle is still accepted.
        if (!rx_fifo_empty) begin
          rx_fifo_rd_en = 1'b1;
          if (rx_fifo_data != byte_reg) begin
            echo_error = 1'b1;
            state_nxt  = S_IDLE;
          end else if (synch) begin
            synch_nxt = 1'b0;
            state_nxt = (count == '0) ? S_DONE : S_SRC_READ;
          end else begin
            count_nxt = count - 1'b1;
            state_nxt = (count == BITS_N'(1)) ? S_DONE : S_SRC_READ;
          end
        end else begin
          to_nxt = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_updi_output_handler.sv
// Bench for updi_output_handler: FIFO environment with TX->RX loopback, table-driven
// transfers, plus hand sequences for timeout, late echo, stalls and async reset.
module tb_updi_output_handler;

  localparam int BITS_N = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              send_synch = 1'b0;
  logic [BITS_N-1:0] n_bytes = '0;
  logic              ready, done, timeout, echo_error;
  logic [7:0]        src_fifo_data = 8'h00;
  logic              src_fifo_empty = 1'b1;
  logic              src_fifo_rd_en;
  logic [7:0]        tx_fifo_data;
  logic              tx_fifo_full = 1'b0;
  logic              tx_fifo_wr_en;
  logic [7:0]        rx_fifo_data = 8'h00;
  logic              rx_fifo_empty = 1'b1;
  logic              rx_fifo_rd_en;

  updi_output_handler #(
    .BITS_N      (BITS_N),
    .TIMEOUT_CLKS(16),
    .SYNCH_BYTE  (8'h55)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .send_synch    (send_synch),
    .n_bytes       (n_bytes),
    .ready         (ready),
    .done          (done),
    .timeout       (timeout),
    .echo_error    (echo_error),
    .src_fifo_data (src_fifo_data),
    .src_fifo_empty(src_fifo_empty),
    .src_fifo_rd_en(src_fifo_rd_en),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .rx_fifo_data  (rx_fifo_data),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_rd_en (rx_fifo_rd_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO environment ----------------
  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int   n_src_pops, n_rx_pops, n_done, n_to, n_err;
  int   tx_idx, corrupt_idx;
  logic [7:0] corrupt_val;
  bit   drop_echo, src_stall;
  bit   p_src, p_tx, p_rx;
  logic [7:0] p_tx_data;

  function automatic void refresh();
    src_fifo_empty = src_stall || (src_q.size() == 0);
    src_fifo_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    rx_fifo_empty  = (rx_q.size() == 0);
    rx_fifo_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  // Outputs are observed mid-cycle; their FIFO effects are applied just after the edge.
  always @(negedge clk) begin
    p_src     = src_fifo_rd_en;
    p_tx      = tx_fifo_wr_en;
    p_tx_data = tx_fifo_data;
    p_rx      = rx_fifo_rd_en;
    if (done)       n_done++;
    if (timeout)    n_to++;
    if (echo_error) n_err++;
  end

  always @(posedge clk) begin
    #1;
    if (p_src) begin
      n_src_pops++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (p_rx) begin
      n_rx_pops++;
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    if (p_tx) begin
      tx_log.push_back(p_tx_data);
      if (!drop_echo) rx_q.push_back((tx_idx == corrupt_idx) ? corrupt_val : p_tx_data);
      tx_idx++;
    end
    p_src = 1'b0;
    p_tx  = 1'b0;
    p_rx  = 1'b0;
    refresh();
  end

  task automatic env_clear();
    src_q.delete();
    rx_q.delete();
    tx_log.delete();
    n_src_pops = 0; n_rx_pops = 0; n_done = 0; n_to = 0; n_err = 0;
    tx_idx = 0; corrupt_idx = -1; corrupt_val = 8'h00;
    drop_echo = 1'b0; src_stall = 1'b0; tx_fifo_full = 1'b0;
    refresh();
  endtask

  task automatic do_start(input bit synch, input logic [BITS_N-1:0] n);
    @(posedge clk); #2;
    start = 1'b1; send_synch = synch; n_bytes = n;
    @(posedge clk); #2;
    start = 1'b0; send_synch = 1'b0; n_bytes = '0;
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (ready) begin seen = 1'b1; break; end
    end
    check({name, " ready_return"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_wr(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (tx_fifo_wr_en) begin seen = 1'b1; break; end
    end
    check({name, " tx_write_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          synch;
    logic [5:0]  n;
    int          nsrc;
    logic [31:0] src;      // byte 0 in [7:0]
    int          cidx;     // echo index to corrupt, -1 none
    logic [7:0]  cval;
    int          ntx;
    logic [31:0] tx;       // expected TX bytes, byte 0 in [7:0]
    int          src_pops;
    int          rx_pops;
    int          ndone;
    int          nerr;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int first_to;

    vecs[0] = '{1'b0, 6'd3, 3, 32'h0033_2211, -1, 8'h00, 3, 32'h0033_2211, 3, 3, 1, 0};
    vecs[1] = '{1'b1, 6'd2, 2, 32'h0000_0CA5, -1, 8'h00, 3, 32'h000C_A555, 2, 3, 1, 0};
    vecs[2] = '{1'b1, 6'd0, 0, 32'h0000_0000, -1, 8'h00, 1, 32'h0000_0055, 0, 1, 1, 0};
    vecs[3] = '{1'b0, 6'd3, 3, 32'h0033_2211,  1, 8'h23, 2, 32'h0000_2211, 2, 2, 0, 1};
    vecs[4] = '{1'b0, 6'd0, 0, 32'h0000_0000, -1, 8'h00, 0, 32'h0000_0000, 0, 0, 1, 0};
    vecs[5] = '{1'b1, 6'd1, 1, 32'h0000_005A,  0, 8'h54, 1, 32'h0000_0055, 0, 1, 0, 1};
    vecs[6] = '{1'b0, 6'd1, 1, 32'h0000_00FF, -1, 8'h00, 1, 32'h0000_00FF, 1, 1, 1, 0};

    env_clear();

    // Reset state
    #12;
    check("rst ready", 32'(ready), 32'd1);
    check("rst pulses", {29'd0, done, timeout, echo_error}, 32'd0);
    check("rst strobes", {29'd0, src_fifo_rd_en, tx_fifo_wr_en, rx_fifo_rd_en}, 32'd0);
    check("rst tx_data", 32'(tx_fifo_data), 32'd0);
    #11 rst_n = 1'b1;

    foreach (vecs[v]) begin
      string nm;
      logic [31:0] srcw, txw;
      nm = $sformatf("vec%0d", v);
      @(posedge clk); #2;
      env_clear();
      srcw = vecs[v].src;
      for (int b = 0; b < vecs[v].nsrc; b++) src_q.push_back(srcw[8*b +: 8]);
      corrupt_idx = vecs[v].cidx;
      corrupt_val = vecs[v].cval;
      refresh();
      do_start(vecs[v].synch, vecs[v].n);
      wait_ready(nm);
      txw = vecs[v].tx;
      check({nm, " tx_count"}, 32'(tx_log.size()), 32'(vecs[v].ntx));
      for (int b = 0; b < vecs[v].ntx && b < tx_log.size(); b++)
        check($sformatf("%s tx_byte%0d", nm, b), 32'(tx_log[b]), 32'(txw[8*b +: 8]));
      check({nm, " src_pops"}, 32'(n_src_pops), 32'(vecs[v].src_pops));
      check({nm, " rx_pops"}, 32'(n_rx_pops), 32'(vecs[v].rx_pops));
      check({nm, " done"}, 32'(n_done), 32'(vecs[v].ndone));
      check({nm, " echo_error"}, 32'(n_err), 32'(vecs[v].nerr));
      check({nm, " timeout"}, 32'(n_to), 32'd0);
    end

    // Timeout: echo never arrives, pulse on the 16th ECHO_WAIT clock
    @(posedge clk); #2;
    env_clear();
    src_q.push_back(8'h77);
    drop_echo = 1'b1;
    refresh();
    do_start(1'b0, 6'd1);
    wait_wr("to");
    first_to = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (timeout && first_to == 0) first_to = k;
    end
    check("to cycle", 32'(first_to), 32'd16);
    wait_ready("to");
    check("to count", 32'(n_to), 32'd1);
    check("to done", 32'(n_done), 32'd0);
    check("to rx_pops", 32'(n_rx_pops), 32'd0);

    // Late echo on the 16th clock wins over the timeout
    @(posedge clk); #2;
    env_clear();
    src_q.push_back(8'h3C);
    drop_echo = 1'b1;
    refresh();
    do_start(1'b0, 6'd1);
    wait_wr("late");
    repeat (15) @(negedge clk);
    @(posedge clk); #2;
    rx_q.push_back(8'h3C);
    refresh();
    @(negedge clk); #1;
    check("late rd_en", 32'(rx_fifo_rd_en), 32'd1);
    check("late no_timeout", 32'(timeout), 32'd0);
    wait_ready("late");
    check("late done", 32'(n_done), 32'd1);
    check("late to_count", 32'(n_to), 32'd0);

    // Source and TX stalls, then async reset during ECHO_WAIT
    @(posedge clk); #2;
    env_clear();
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    src_stall = 1'b1;
    tx_fifo_full = 1'b1;
    refresh();
    do_start(1'b0, 6'd3);
    repeat (4) @(posedge clk);
    #2;
    check("stall src_pops", 32'(n_src_pops), 32'd0);
    check("stall src ready", 32'(ready), 32'd0);
    src_stall = 1'b0;
    refresh();
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    check("stall tx pops", 32'(n_src_pops), 32'd1);
    check("stall tx pushes", 32'(tx_log.size()), 32'd0);
    check("stall tx_data", 32'(tx_fifo_data), 32'h11);
    tx_fifo_full = 1'b0;
    drop_echo = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst ready", 32'(ready), 32'd1);
    check("arst strobes", {29'd0, src_fifo_rd_en, tx_fifo_wr_en, rx_fifo_rd_en}, 32'd0);
    check("arst pushes", 32'(tx_log.size()), 32'd1);
    check("arst rx_pops", 32'(n_rx_pops), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("arst pulses", 32'(n_done + n_to + n_err), 32'd0);
    check("arst idle", 32'(ready), 32'd1);
    check("arst src_pops", 32'(n_src_pops), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
